// File: rtl/sgpio_target_framer.sv
// SGPIO target framer: deserialises the master's SDataOut stream into a
// frame-wide parallel word, checks the length of each frame, and publishes
// the word only after LOCK_FRAMES good frames in a row. Local status is
// shifted back to the master on SDataIn, LSB first, one cycle behind input.
module sgpio_target_framer #(
    parameter int NUM_DRIVES     = 4,
    parameter int BITS_PER_DRIVE = 3,
    parameter int LOCK_FRAMES    = 2,
    parameter int CLEAR_ON_LOSS  = 1
) (
    input  logic                                 iClk,
    input  logic                                 iRst,
    input  logic                                 iLoad,
    input  logic                                 iSData,
    input  logic [NUM_DRIVES*BITS_PER_DRIVE-1:0] iPData,
    output logic                                 oSData,
    output logic [NUM_DRIVES*BITS_PER_DRIVE-1:0] oPData,
    output logic                                 oFrameValid,
    output logic                                 oFrameErr,
    output logic                                 oLocked,
    output logic [7:0]                           oErrCnt
);

    localparam int FB = NUM_DRIVES * BITS_PER_DRIVE;
    // Counter reaches FB+1 so an over-long frame stays distinguishable from a good one.
    localparam int CW = $clog2(FB + 2);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      good_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [FB-1:0]   acc_q;
    logic [FB-1:0]   acc_d;
    logic [FB-1:0]   tx_q;
    logic [FB-1:0]   tx_shift;
    logic [CW-1:0]   tx_cnt_q;
    logic            sdata_q;
    logic [FB-1:0]   pdata_q;
    logic            fv_q;
    logic            fe_q;
    logic [7:0]      err_q;
    logic            frame_good;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A frame is good only when exactly FB bits were seen since the last load.
    assign frame_good = (bit_cnt_q == CW'(FB));
    assign tx_shift   = tx_q >> tx_cnt_q;

    // Next accumulator: the load cycle writes bit 0, later cycles fill bit rBitCnt.
    always_comb begin
        acc_d = acc_q;
        if (iLoad) begin
            acc_d[0] = iSData;
        end else begin
            for (int i = 0; i < FB; i++) begin
                if (bit_cnt_q == CW'(i)) begin
                    acc_d[i] = iSData;
                end
            end
        end
    end

    // Receive shift storage; publish reads acc_q before this edge overwrites bit 0.
    always_ff @(posedge iClk) begin
        acc_q <= acc_d;
    end

    // Receive bit counter, restarted by iLoad and saturating one past a full frame.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            bit_cnt_q <= '0;
        end else if (iLoad) begin
            bit_cnt_q <= CW'(1);
        end else if (bit_cnt_q < CW'(FB + 1)) begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
        end
    end

    // Lock state machine with registered publish/error outputs, evaluated on frame close.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= HUNT;
            good_q  <= '0;
            pdata_q <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            fv_q <= 1'b0;
            fe_q <= 1'b0;
            if (iLoad) begin
                case (state_q)
                    HUNT: begin
                        state_q <= SYNC;
                        good_q  <= '0;
                    end
                    SYNC: begin
                        if (frame_good) begin
                            if (({1'b0, good_q} + 5'd1) == 5'(LOCK_FRAMES)) begin
                                state_q <= LOCKED;
                                good_q  <= '0;
                                pdata_q <= acc_q;
                                fv_q    <= 1'b1;
                            end else begin
                                good_q <= good_q + 4'd1;
                            end
                        end else begin
                            good_q <= '0;
                            fe_q   <= 1'b1;
                            err_q  <= sat_inc8(err_q);
                        end
                    end
                    LOCKED: begin
                        if (frame_good) begin
                            pdata_q <= acc_q;
                            fv_q    <= 1'b1;
                        end else begin
                            state_q <= SYNC;
                            good_q  <= '0;
                            fe_q    <= 1'b1;
                            err_q   <= sat_inc8(err_q);
                            if (CLEAR_ON_LOSS != 0) begin
                                pdata_q <= '0;
                            end
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        good_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Capture local status at the load cycle for the return stream.
    always_ff @(posedge iClk) begin
        if (iLoad) begin
            tx_q <= iPData;
        end
    end

    // Return serialiser: bit 0 leaves at the load edge, bit k k cycles later, then zeros.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            tx_cnt_q <= CW'(FB);
            sdata_q  <= 1'b0;
        end else if (iLoad) begin
            tx_cnt_q <= CW'(1);
            sdata_q  <= iPData[0];
        end else begin
            sdata_q <= (tx_cnt_q < CW'(FB)) ? tx_shift[0] : 1'b0;
            if (tx_cnt_q < CW'(FB)) begin
                tx_cnt_q <= tx_cnt_q + CW'(1);
            end
        end
    end

    assign oSData      = sdata_q;
    assign oPData      = pdata_q;
    assign oFrameValid = fv_q;
    assign oFrameErr   = fe_q;
    assign oLocked     = (state_q == LOCKED);
    assign oErrCnt     = err_q;

endmodule

// File: tb/tb_sgpio_target_framer.sv
// Bench for sgpio_target_framer: two instances (12-bit frame, lock after 2,
// clear on loss; 16-bit frame, lock after 1, hold on loss) share one serial
// stream and are compared cycle by cycle against a frame-level reference model.
module tb_sgpio_target_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, sd;
    logic [11:0] pd0;
    logic [15:0] pd1;
    logic        sdo0, sdo1, fv0, fv1, fe0, fe1, lk0, lk1;
    logic [11:0] po0;
    logic [15:0] po1;
    logic [7:0]  ec0, ec1;

    sgpio_target_framer #(.NUM_DRIVES(4), .BITS_PER_DRIVE(3), .LOCK_FRAMES(2), .CLEAR_ON_LOSS(1)) u0 (
        .iClk(clk), .iRst(rst), .iLoad(load), .iSData(sd), .iPData(pd0),
        .oSData(sdo0), .oPData(po0), .oFrameValid(fv0), .oFrameErr(fe0),
        .oLocked(lk0), .oErrCnt(ec0));

    sgpio_target_framer #(.NUM_DRIVES(8), .BITS_PER_DRIVE(2), .LOCK_FRAMES(1), .CLEAR_ON_LOSS(0)) u1 (
        .iClk(clk), .iRst(rst), .iLoad(load), .iSData(sd), .iPData(pd1),
        .oSData(sdo1), .oPData(po1), .oFrameValid(fv1), .oFrameErr(fe1),
        .oLocked(lk1), .oErrCnt(ec1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state, one slot per instance.
    int          fbv  [2] = '{12, 16};
    int          lkv  [2] = '{2, 1};
    int          clrv [2] = '{1, 0};
    bit          m_hunt [2];
    bit          m_lock [2];
    int          m_good [2];
    logic [31:0] m_pd   [2];
    int          m_err  [2];
    bit          m_fv   [2];
    bit          m_fe   [2];
    bit          m_sd   [2];
    bit          m_sd_ok;
    logic [31:0] cur_pd [2];
    int          prev_len;
    logic [31:0] prev_bits;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hunt[k] = 1'b1; m_lock[k] = 1'b0; m_good[k] = 0; m_pd[k] = '0;
            m_err[k] = 0; m_fv[k] = 1'b0; m_fe[k] = 1'b0; m_sd[k] = 1'b0;
        end
        m_sd_ok = 1'b1;
    endfunction

    // Evaluate a completed frame of length L whose bits are given LSB first.
    function automatic void model_close(int k, int L, logic [31:0] bits);
        logic [31:0] mask;
        mask = (32'h1 << fbv[k]) - 32'h1;
        m_fv[k] = 1'b0;
        m_fe[k] = 1'b0;
        if (m_hunt[k]) begin
            m_hunt[k] = 1'b0;
            m_good[k] = 0;
        end else if (L == fbv[k]) begin
            if (!m_lock[k]) begin
                m_good[k]++;
                if (m_good[k] >= lkv[k]) m_lock[k] = 1'b1;
            end
            if (m_lock[k]) begin
                m_pd[k] = bits & mask;
                m_fv[k] = 1'b1;
            end
        end else begin
            m_fe[k]   = 1'b1;
            m_err[k]  = (m_err[k] < 255) ? m_err[k] + 1 : 255;
            m_good[k] = 0;
            if (m_lock[k]) begin
                m_lock[k] = 1'b0;
                if (clrv[k] != 0) m_pd[k] = '0;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("valid0",  32'(fv0),  32'(m_fv[0]));
        chk("err0",    32'(fe0),  32'(m_fe[0]));
        chk("locked0", 32'(lk0),  32'(m_lock[0]));
        chk("pdata0",  32'(po0),  m_pd[0]);
        chk("errcnt0", 32'(ec0),  32'(m_err[0]));
        chk("valid1",  32'(fv1),  32'(m_fv[1]));
        chk("err1",    32'(fe1),  32'(m_fe[1]));
        chk("locked1", 32'(lk1),  32'(m_lock[1]));
        chk("pdata1",  32'(po1),  m_pd[1]);
        chk("errcnt1", 32'(ec1),  32'(m_err[1]));
        if (m_sd_ok) begin
            chk("sdata0", 32'(sdo0), 32'(m_sd[0]));
            chk("sdata1", 32'(sdo1), 32'(m_sd[1]));
        end
    endtask

    // Drive one frame of len cycles; rst_at >= 1 pulses reset at that cycle.
    task automatic send_frame(input int len, input logic [31:0] bits, input int rst_at,
                              input logic [11:0] p0, input logic [15:0] p1);
        for (int j = 0; j < len; j++) begin
            rst  = (j == rst_at);
            load = (j == 0);
            sd   = (j < 32) ? bits[j] : 1'($urandom);
            if (j == 0) begin
                pd0 = p0;
                pd1 = p1;
            end else begin
                pd0 = 12'($urandom);
                pd1 = 16'($urandom);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                model_reset();
                m_sd_ok = 1'b0;
            end else begin
                if (j == 0) begin
                    for (int k = 0; k < 2; k++) model_close(k, prev_len, prev_bits);
                    prev_len  = len;
                    prev_bits = bits;
                    cur_pd[0] = 32'(p0);
                    cur_pd[1] = 32'(p1);
                    m_sd_ok   = 1'b1;
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        m_fv[k] = 1'b0;
                        m_fe[k] = 1'b0;
                    end
                end
                for (int k = 0; k < 2; k++)
                    m_sd[k] = (j < fbv[k]) ? cur_pd[k][j] : 1'b0;
            end
            check_outputs();
        end
        rst = 1'b0;
    endtask

    int len_tab [12] = '{12, 12, 12, 16, 16, 16, 11, 13, 14, 1, 17, 5};

    initial begin
        rst = 1'b1; load = 1'b0; sd = 1'b0; pd0 = '0; pd1 = '0;
        prev_len = 0; prev_bits = '0;
        cur_pd[0] = '0; cur_pd[1] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Lock on 0xA5C and return 0x3C1 on the first frame.
        send_frame(12, 32'hA5C, -1, 12'h3C1, 16'h3C1);
        for (int i = 0; i < 3; i++) send_frame(12, 32'hA5C, -1, 12'($urandom), 16'($urandom));
        chk("t1_pdata", 32'(po0), 32'hA5C);
        chk("t1_locked", 32'(lk0), 32'd1);

        // Short frame while locked, then relock.
        send_frame(11, 32'h7FF, -1, 12'($urandom), 16'($urandom));
        send_frame(12, 32'h123, -1, 12'($urandom), 16'($urandom));
        chk("t3_locked", 32'(lk0), 32'd0);
        chk("t3_pdata", 32'(po0), 32'd0);
        chk("t3_errcnt", 32'(ec0), 32'd1);
        for (int i = 0; i < 3; i++) send_frame(12, 32'h456, -1, 12'($urandom), 16'($urandom));

        // Long frame with extra bits set, then good frames.
        send_frame(14, 32'h3ABC, -1, 12'($urandom), 16'($urandom));
        for (int i = 0; i < 3; i++) send_frame(12, 32'($urandom), -1, 12'($urandom), 16'($urandom));

        // 16-bit frames lock the second instance; a bad frame must keep its data.
        for (int i = 0; i < 3; i++) send_frame(16, 32'h0000BEEF, -1, 12'($urandom), 16'($urandom));
        send_frame(9, 32'($urandom), -1, 12'($urandom), 16'($urandom));
        send_frame(16, 32'($urandom), -1, 12'($urandom), 16'($urandom));
        chk("hold_pdata1", 32'(po1), 32'h0000BEEF);

        // Reset mid-frame while locked.
        for (int i = 0; i < 3; i++) send_frame(12, 32'($urandom), -1, 12'($urandom), 16'($urandom));
        send_frame(12, 32'($urandom), 5, 12'($urandom), 16'($urandom));
        send_frame(12, 32'($urandom), -1, 12'($urandom), 16'($urandom));
        chk("t5_novalid", 32'(lk0), 32'd0);

        // Randomized runs of frame lengths, with occasional resets.
        for (int i = 0; i < 150; i++) begin
            int len;
            int reps;
            len  = len_tab[$urandom_range(0, 11)];
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                int ra;
                ra = -1;
                if (len > 1 && $urandom_range(0, 29) == 0) ra = $urandom_range(1, len - 1);
                send_frame(len, 32'($urandom), ra, 12'($urandom), 16'($urandom));
            end
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) send_frame(5, 32'($urandom), -1, 12'($urandom), 16'($urandom));
        send_frame(12, 32'($urandom), -1, 12'($urandom), 16'($urandom));
        chk("sat_errcnt0", 32'(ec0), 32'd255);
        chk("sat_errcnt1", 32'(ec1), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
